// File: rtl/hub75_output_stage_if.sv
// Signal bundle between the scan stage and the HUB75 output stage.
// The master drives the scan-side inputs; the slave (output stage) drives the panel pins.
interface hub75_output_stage_if;
    logic       guard_enable;
    logic       clk_pixel_in;
    logic       row_latch_in;
    logic       output_enable_in;
    logic [3:0] row_address_in;
    logic [2:0] rgb1_in;
    logic [2:0] rgb2_in;
    logic       clk_pixel_out;
    logic       row_latch_out;
    logic       oe_n_out;
    logic [3:0] row_address_out;
    logic [2:0] rgb1_out;
    logic [2:0] rgb2_out;
    logic       blanking;
    logic [7:0] row_change_count;

    modport master (
        output guard_enable, clk_pixel_in, row_latch_in, output_enable_in,
               row_address_in, rgb1_in, rgb2_in,
        input  clk_pixel_out, row_latch_out, oe_n_out, row_address_out,
               rgb1_out, rgb2_out, blanking, row_change_count
    );

    modport slave (
        input  guard_enable, clk_pixel_in, row_latch_in, output_enable_in,
               row_address_in, rgb1_in, rgb2_in,
        output clk_pixel_out, row_latch_out, oe_n_out, row_address_out,
               rgb1_out, rgb2_out, blanking, row_change_count
    );
endinterface

// File: rtl/hub75_output_stage.sv
// HUB75 panel output register stage with ghost blanking: the panel is held dark for
// PRE_TICKS cycles before and POST_TICKS cycles after every row-address change.
module hub75_output_stage #(
    parameter int                   CNT_WIDTH  = 4,
    parameter logic [CNT_WIDTH-1:0] PRE_TICKS  = 4'd2,
    parameter logic [CNT_WIDTH-1:0] POST_TICKS = 4'd3
) (
    input  logic                 clk_in,
    input  logic                 reset,
    hub75_output_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] PRE_LOAD  = PRE_TICKS - CNT_ONE;
    localparam logic [CNT_WIDTH-1:0] POST_LOAD = POST_TICKS - CNT_ONE;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]           target_row_q, target_row_d;
    logic [3:0]           pending_row_q, pending_row_d;
    logic [3:0]           row_address_q, row_address_d;
    logic [7:0]           row_change_count_q, row_change_count_d;
    logic                 oe_n_q, oe_n_d;
    logic                 blanking_q, blanking_d;
    logic                 clk_pixel_q, row_latch_q;
    logic [2:0]           rgb1_q, rgb2_q;
    logic                 row_change_s;

    // Blanking sequencer: a new row always restarts PRE, even on a terminal count.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        target_row_d       = target_row_q;
        pending_row_d      = pending_row_q;
        row_address_d      = row_address_q;
        row_change_count_d = row_change_count_q;
        row_change_s       = bus.guard_enable && (bus.row_address_in != target_row_q);

        if (!bus.guard_enable) begin
            state_d       = ST_PASS;
            cnt_d         = '0;
            row_address_d = bus.row_address_in;
            target_row_d  = bus.row_address_in;
        end else if (row_change_s) begin
            state_d            = ST_PRE;
            cnt_d              = PRE_LOAD;
            pending_row_d      = bus.row_address_in;
            target_row_d       = bus.row_address_in;
            row_change_count_d = row_change_count_q + 8'd1;
        end else begin
            case (state_q)
                ST_PASS: state_d = ST_PASS;
                ST_PRE: begin
                    if (cnt_q == '0) begin
                        state_d       = ST_POST;
                        row_address_d = pending_row_q;
                        cnt_d         = POST_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_POST: begin
                    if (cnt_q == '0) begin
                        state_d = ST_PASS;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: state_d = ST_PASS;
            endcase
        end

        // Latch pulses darken the panel only while the guard is active.
        if (state_d != ST_PASS) begin
            oe_n_d = 1'b1;
        end else if (bus.guard_enable) begin
            oe_n_d = ~bus.output_enable_in | bus.row_latch_in;
        end else begin
            oe_n_d = ~bus.output_enable_in;
        end
        blanking_d = (state_d != ST_PASS);
    end

    // State and output registers; reset leaves the panel dark.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q            <= ST_PASS;
            cnt_q              <= '0;
            target_row_q       <= 4'd0;
            pending_row_q      <= 4'd0;
            row_address_q      <= 4'd0;
            row_change_count_q <= 8'd0;
            oe_n_q             <= 1'b1;
            blanking_q         <= 1'b0;
            clk_pixel_q        <= 1'b0;
            row_latch_q        <= 1'b0;
            rgb1_q             <= 3'd0;
            rgb2_q             <= 3'd0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            target_row_q       <= target_row_d;
            pending_row_q      <= pending_row_d;
            row_address_q      <= row_address_d;
            row_change_count_q <= row_change_count_d;
            oe_n_q             <= oe_n_d;
            blanking_q         <= blanking_d;
            clk_pixel_q        <= bus.clk_pixel_in;
            row_latch_q        <= bus.row_latch_in;
            rgb1_q             <= bus.rgb1_in;
            rgb2_q             <= bus.rgb2_in;
        end
    end

    assign bus.clk_pixel_out    = clk_pixel_q;
    assign bus.row_latch_out    = row_latch_q;
    assign bus.oe_n_out         = oe_n_q;
    assign bus.row_address_out  = row_address_q;
    assign bus.rgb1_out         = rgb1_q;
    assign bus.rgb2_out         = rgb2_q;
    assign bus.blanking         = blanking_q;
    assign bus.row_change_count = row_change_count_q;
endmodule

// File: tb/tb_hub75_output_stage.sv
// Directed, table-driven bench for hub75_output_stage (PRE_TICKS=2, POST_TICKS=3).
module tb_hub75_output_stage;
    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   n_vec  = 0;
    int   n_err  = 0;

    hub75_output_stage_if bus ();

    hub75_output_stage #(
        .CNT_WIDTH (4),
        .PRE_TICKS (4'd2),
        .POST_TICKS(4'd3)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       rst;
        logic       g;
        logic       oe;
        logic       lat;
        logic [3:0] row;
        logic       exp_oe_n;
        logic [3:0] exp_row;
        logic       exp_blank;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic g, input logic oe, input logic lat,
                       input logic [3:0] row, input logic eo, input logic [3:0] er,
                       input logic eb, input logic [7:0] ec);
        vec_t v;
        v.rst = rst; v.g = g; v.oe = oe; v.lat = lat; v.row = row;
        v.exp_oe_n = eo; v.exp_row = er; v.exp_blank = eb; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_tick(input logic rst, input logic g, input logic oe,
                              input logic lat, input logic [3:0] row, input logic [2:0] pat);
        @(negedge clk_in);
        reset                = rst;
        bus.guard_enable     = g;
        bus.output_enable_in = oe;
        bus.row_latch_in     = lat;
        bus.row_address_in   = row;
        bus.rgb1_in          = pat;
        bus.rgb2_in          = ~pat;
        bus.clk_pixel_in     = pat[0];
        @(posedge clk_in);
        #1;
        n_vec++;
    endtask

    initial begin
        logic [2:0] pat;
        logic [3:0] r;
        bus.guard_enable = 1'b1; bus.output_enable_in = 1'b1; bus.row_latch_in = 1'b0;
        bus.row_address_in = 4'd0; bus.rgb1_in = 3'd0; bus.rgb2_in = 3'd0;
        bus.clk_pixel_in = 1'b0;

        //  rst g  oe lat row | oe_n row blank count
        add(1'b1,1'b1,1'b1,1'b1,4'd0, 1'b1,4'd0,1'b0,8'd0);  // reset beats inputs
        add(1'b1,1'b1,1'b1,1'b0,4'd0, 1'b1,4'd0,1'b0,8'd0);
        add(1'b0,1'b1,1'b1,1'b0,4'd0, 1'b0,4'd0,1'b0,8'd0);
        add(1'b0,1'b1,1'b1,1'b0,4'd0, 1'b0,4'd0,1'b0,8'd0);
        add(1'b0,1'b1,1'b1,1'b1,4'd0, 1'b1,4'd0,1'b0,8'd0);  // latch darkens
        add(1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd0,1'b0,8'd0);
        add(1'b0,1'b1,1'b1,1'b0,4'd0, 1'b0,4'd0,1'b0,8'd0);
        add(1'b0,1'b1,1'b1,1'b0,4'd1, 1'b1,4'd0,1'b1,8'd1);  // 0->1 at k
        add(1'b0,1'b1,1'b1,1'b0,4'd1, 1'b1,4'd0,1'b1,8'd1);
        add(1'b0,1'b1,1'b1,1'b0,4'd1, 1'b1,4'd1,1'b1,8'd1);  // k+2 address moves
        add(1'b0,1'b1,1'b1,1'b0,4'd1, 1'b1,4'd1,1'b1,8'd1);
        add(1'b0,1'b1,1'b1,1'b0,4'd1, 1'b1,4'd1,1'b1,8'd1);
        add(1'b0,1'b1,1'b1,1'b0,4'd1, 1'b0,4'd1,1'b0,8'd1);  // k+5 lit
        add(1'b0,1'b1,1'b1,1'b0,4'd2, 1'b1,4'd1,1'b1,8'd2);  // 1->2
        add(1'b0,1'b1,1'b1,1'b0,4'd3, 1'b1,4'd1,1'b1,8'd3);  // 2->3 during PRE
        add(1'b0,1'b1,1'b1,1'b0,4'd3, 1'b1,4'd1,1'b1,8'd3);
        add(1'b0,1'b1,1'b1,1'b0,4'd3, 1'b1,4'd3,1'b1,8'd3);  // direct 1->3
        add(1'b0,1'b1,1'b1,1'b0,4'd3, 1'b1,4'd3,1'b1,8'd3);
        add(1'b0,1'b1,1'b1,1'b0,4'd3, 1'b1,4'd3,1'b1,8'd3);
        add(1'b0,1'b1,1'b1,1'b0,4'd3, 1'b0,4'd3,1'b0,8'd3);
        add(1'b0,1'b1,1'b1,1'b0,4'd4, 1'b1,4'd3,1'b1,8'd4);  // k
        add(1'b0,1'b1,1'b1,1'b0,4'd4, 1'b1,4'd3,1'b1,8'd4);
        add(1'b0,1'b1,1'b1,1'b0,4'd4, 1'b1,4'd4,1'b1,8'd4);  // k+2
        add(1'b0,1'b1,1'b1,1'b0,4'd5, 1'b1,4'd4,1'b1,8'd5);  // k+3 change in POST
        add(1'b0,1'b1,1'b1,1'b0,4'd5, 1'b1,4'd4,1'b1,8'd5);
        add(1'b0,1'b1,1'b1,1'b0,4'd5, 1'b1,4'd5,1'b1,8'd5);  // k+5
        add(1'b0,1'b1,1'b1,1'b0,4'd5, 1'b1,4'd5,1'b1,8'd5);
        add(1'b0,1'b1,1'b1,1'b0,4'd5, 1'b1,4'd5,1'b1,8'd5);
        add(1'b0,1'b1,1'b1,1'b0,4'd5, 1'b0,4'd5,1'b0,8'd5);
        add(1'b0,1'b1,1'b1,1'b0,4'd6, 1'b1,4'd5,1'b1,8'd6);
        add(1'b0,1'b1,1'b1,1'b0,4'd6, 1'b1,4'd5,1'b1,8'd6);  // PRE at zero
        add(1'b0,1'b1,1'b1,1'b0,4'd7, 1'b1,4'd5,1'b1,8'd7);  // change wins over PRE end
        add(1'b0,1'b1,1'b1,1'b0,4'd7, 1'b1,4'd5,1'b1,8'd7);
        add(1'b0,1'b1,1'b1,1'b0,4'd7, 1'b1,4'd7,1'b1,8'd7);
        add(1'b0,1'b1,1'b1,1'b0,4'd7, 1'b1,4'd7,1'b1,8'd7);
        add(1'b0,1'b1,1'b1,1'b0,4'd7, 1'b1,4'd7,1'b1,8'd7);  // POST at zero
        add(1'b0,1'b1,1'b1,1'b0,4'd8, 1'b1,4'd7,1'b1,8'd8);  // change wins over POST end
        add(1'b0,1'b1,1'b1,1'b0,4'd8, 1'b1,4'd7,1'b1,8'd8);
        add(1'b0,1'b1,1'b1,1'b0,4'd8, 1'b1,4'd8,1'b1,8'd8);
        add(1'b0,1'b1,1'b1,1'b0,4'd8, 1'b1,4'd8,1'b1,8'd8);
        add(1'b0,1'b1,1'b1,1'b0,4'd8, 1'b1,4'd8,1'b1,8'd8);
        add(1'b0,1'b1,1'b1,1'b0,4'd8, 1'b0,4'd8,1'b0,8'd8);
        add(1'b0,1'b0,1'b1,1'b0,4'd4, 1'b0,4'd4,1'b0,8'd8);  // guard off: passthrough
        add(1'b0,1'b0,1'b1,1'b0,4'd5, 1'b0,4'd5,1'b0,8'd8);
        add(1'b0,1'b1,1'b1,1'b0,4'd5, 1'b0,4'd5,1'b0,8'd8);  // guard on: no blank
        add(1'b0,1'b1,1'b1,1'b0,4'd6, 1'b1,4'd5,1'b1,8'd9);
        add(1'b0,1'b0,1'b1,1'b0,4'd6, 1'b0,4'd6,1'b0,8'd9);  // abort mid-blank
        add(1'b0,1'b1,1'b1,1'b0,4'd6, 1'b0,4'd6,1'b0,8'd9);
        add(1'b0,1'b0,1'b1,1'b1,4'd6, 1'b0,4'd6,1'b0,8'd9);  // latch ignored, guard off
        add(1'b0,1'b0,1'b0,1'b0,4'd6, 1'b1,4'd6,1'b0,8'd9);
        add(1'b0,1'b1,1'b1,1'b0,4'd6, 1'b0,4'd6,1'b0,8'd9);
        add(1'b0,1'b1,1'b1,1'b0,4'd7, 1'b1,4'd6,1'b1,8'd10);
        add(1'b0,1'b1,1'b1,1'b0,4'd7, 1'b1,4'd6,1'b1,8'd10);
        add(1'b0,1'b1,1'b1,1'b0,4'd7, 1'b1,4'd7,1'b1,8'd10); // POST
        add(1'b1,1'b1,1'b1,1'b0,4'd7, 1'b1,4'd0,1'b0,8'd0);  // reset in POST
        add(1'b0,1'b1,1'b1,1'b0,4'd0, 1'b0,4'd0,1'b0,8'd0);
        add(1'b0,1'b1,1'b1,1'b0,4'd0, 1'b0,4'd0,1'b0,8'd0);
        add(1'b0,1'b1,1'b1,1'b0,4'd2, 1'b1,4'd0,1'b1,8'd1);
        add(1'b1,1'b1,1'b1,1'b0,4'd3, 1'b1,4'd0,1'b0,8'd0);  // reset beats change in PRE
        add(1'b0,1'b1,1'b1,1'b0,4'd0, 1'b0,4'd0,1'b0,8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            pat = 3'(i);
            drive_tick(vecs[i].rst, vecs[i].g, vecs[i].oe, vecs[i].lat, vecs[i].row, pat);
            chk("oe_n_out",         i, {7'd0, bus.oe_n_out},        {7'd0, vecs[i].exp_oe_n});
            chk("row_address_out",  i, {4'd0, bus.row_address_out}, {4'd0, vecs[i].exp_row});
            chk("blanking",         i, {7'd0, bus.blanking},        {7'd0, vecs[i].exp_blank});
            chk("row_change_count", i, bus.row_change_count,        vecs[i].exp_cnt);
            chk("rgb1_out",  i, {5'd0, bus.rgb1_out},      vecs[i].rst ? 8'd0 : {5'd0, pat});
            chk("rgb2_out",  i, {5'd0, bus.rgb2_out},      vecs[i].rst ? 8'd0 : {5'd0, ~pat});
            chk("clk_pixel", i, {7'd0, bus.clk_pixel_out}, vecs[i].rst ? 8'd0 : {7'd0, pat[0]});
            chk("row_latch", i, {7'd0, bus.row_latch_out}, vecs[i].rst ? 8'd0 : {7'd0, vecs[i].lat});
        end

        // Change the row every cycle: each change is accepted and the counter wraps.
        for (int i = 0; i < 256; i++) begin
            r = (i % 2 == 0) ? 4'd1 : 4'd0;
            drive_tick(1'b0, 1'b1, 1'b1, 1'b0, r, 3'd0);
            if (i == 254) chk("count_255", i, bus.row_change_count, 8'd255);
            if (i == 128) chk("row_held", i, {4'd0, bus.row_address_out}, 8'd0);
        end
        chk("count_wrap",     256, bus.row_change_count,      8'd0);
        chk("wrap_blanking",  256, {7'd0, bus.blanking},      8'd1);
        for (int i = 0; i < 4; i++) drive_tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0);
        chk("tail_oe_dark",   260, {7'd0, bus.oe_n_out},      8'd1);
        drive_tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0);
        chk("tail_oe_lit",    261, {7'd0, bus.oe_n_out},      8'd0);
        chk("tail_blanking",  261, {7'd0, bus.blanking},      8'd0);
        chk("tail_row",       261, {4'd0, bus.row_address_out}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
